// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core (add/sub/and/or/slt/lw/sw/beq/addi/j) that shares one
// instruction/data memory port using a req/ready handshake.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ADDR_W       = 32,
  parameter bit          ILLEGAL_TRAP = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic [3:0]        state,
  output logic              illegal_instr,
  output logic              halted
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
    StAluWb, StAddiEx, StAddiWb, StBranch, StJump, StHalt
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnSlt   = 6'h2A;

  state_e      state_q, state_d, decode_next;
  logic        mem_req_q, mem_req_d, mem_we_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, mdr_q;
  logic [31:0] rf_q [32];
  logic [31:0] rf_a, rf_b, imm_sext, alu_res;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic        legal, acc_done;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rf_a     = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rf_b     = (rt == 5'd0) ? 32'h0 : rf_q[rt];
  // mem_req_q is low in the first FETCH cycle after reset, so ready is ignored there.
  assign acc_done = mem_req_q & mem_ready;

  always_comb begin
    legal       = 1'b1;
    decode_next = StFetch;
    case (op)
      OpRtype: begin
        if (funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt}) decode_next = StExec;
        else legal = 1'b0;
      end
      OpLw, OpSw: decode_next = StMemAdr;
      OpBeq:      decode_next = StBranch;
      OpAddi:     decode_next = StAddiEx;
      OpJ:        decode_next = StJump;
      default:    legal = 1'b0;
    endcase
    if (!legal) decode_next = ILLEGAL_TRAP ? StHalt : StFetch;
  end

  always_comb begin
    case (funct)
      FnAdd:   alu_res = a_q + b_q;
      FnSub:   alu_res = a_q - b_q;
      FnAnd:   alu_res = a_q & b_q;
      FnOr:    alu_res = a_q | b_q;
      FnSlt:   alu_res = {31'h0, $signed(a_q) < $signed(b_q)};
      default: alu_res = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (acc_done) state_d = StDecode;
      StDecode: state_d = decode_next;
      StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (acc_done) state_d = StMemWb;
      StMemWr:  if (acc_done) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
    mem_req_d = state_d inside {StFetch, StMemRd, StMemWr};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      aluout_q  <= '0;
      mdr_q     <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= (state_d == StMemWr);
      unique case (state_q)
        StFetch: begin
          if (acc_done) begin
            ir_q <= mem_rdata;
            pc_q <= pc_q + 32'd4;
          end
        end
        StDecode: begin
          a_q      <= rf_a;
          b_q      <= rf_b;
          aluout_q <= pc_q + (imm_sext << 2);
        end
        StMemAdr, StAddiEx: aluout_q <= a_q + imm_sext;
        StMemRd:  if (acc_done) mdr_q <= mem_rdata;
        StMemWb:  if (rt != 5'd0) rf_q[rt] <= mdr_q;
        StExec:   aluout_q <= alu_res;
        StAluWb:  if (rd != 5'd0) rf_q[rd] <= aluout_q;
        StAddiWb: if (rt != 5'd0) rf_q[rt] <= aluout_q;
        StBranch: if (a_q == b_q) pc_q <= aluout_q;
        StJump:   pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
        default:  ;
      endcase
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = (state_q == StFetch) ? pc_q[ADDR_W-1:0] : aluout_q[ADDR_W-1:0];
  assign mem_wdata     = b_q;
  assign pc            = pc_q;
  assign state         = state_q;
  assign illegal_instr = (state_q == StDecode) && !legal;
  assign halted        = (state_q == StHalt);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: a word memory with configurable wait
// states plus a second core instance built with ILLEGAL_TRAP=1 and ADDR_W=16.
module tb_mips_multicycle_core;

  localparam logic [5:0] OpJ = 6'h02, OpBeq = 6'h04, OpAddi = 6'h08, OpLw = 6'h23, OpSw = 6'h2B;
  localparam logic [5:0] FnAdd = 6'h20, FnSub = 6'h22, FnAnd = 6'h24, FnOr = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_req, mem_we, mem_ready, illegal_instr, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [3:0]  state;

  logic        reset2;
  logic        req2, we2, ill2, halt2;
  logic [15:0] addr2;
  logic [31:0] wdata2, pc2;
  logic [3:0]  state2;

  mips_multicycle_core #(.RESET_PC(32'h40), .ADDR_W(32), .ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .state(state), .illegal_instr(illegal_instr), .halted(halted)
  );

  mips_multicycle_core #(.RESET_PC(32'h0001_0008), .ADDR_W(16), .ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk(clk), .reset(reset2), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_rdata(32'hFC00_0000), .mem_ready(1'b1), .pc(pc2),
    .state(state2), .illegal_instr(ill2), .halted(halt2)
  );

  // Program image is copied into the live memory while reset is low.
  logic [31:0] prog [1024];
  logic [31:0] mem  [1024];
  int          waits = 0;
  int          wcnt;

  assign mem_ready = (wcnt == waits);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (!reset) begin
      mem  <= prog;
      wcnt <= 0;
    end else begin
      if (mem_req && !mem_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (mem_req && mem_we && mem_ready) mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  int          cyc, ill_cnt, wr_cnt, wr_hold, first_wr_hold;
  int          fetch_cyc [1024];
  logic [31:0] first_wr_addr, first_wr_data;

  always @(negedge clk) begin
    if (!reset) begin
      cyc = 0; ill_cnt = 0; wr_cnt = 0; wr_hold = 0; first_wr_hold = 0;
      first_wr_addr = '0; first_wr_data = '0;
      foreach (fetch_cyc[i]) fetch_cyc[i] = -1;
    end else begin
      cyc++;
      if (mem_req && state == 4'd0 && fetch_cyc[mem_addr[11:2]] < 0)
        fetch_cyc[mem_addr[11:2]] = cyc;
      if (illegal_instr) ill_cnt++;
      if (mem_req && mem_we) begin
        wr_hold++;
        if (mem_ready) begin
          if (wr_cnt == 0) begin
            first_wr_addr = mem_addr; first_wr_data = mem_wdata; first_wr_hold = wr_hold;
          end
          wr_cnt++;
          wr_hold = 0;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [31:0] target);
    return {OpJ, target[27:2]};
  endfunction

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = 32'h0;
  endtask

  task automatic do_reset(int w);
    reset = 1'b0;
    waits = w;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic run(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_prog();
    prog[16] = enc_i(OpAddi, 5'd0, 5'd1, 16'd5);
    prog[17] = enc_j(32'h44);
    reset = 1'b0;
    waits = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", mem_we); end
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL rst_pc got %h want 40", pc); end
    checks++; if (halted !== 1'b0 || illegal_instr !== 1'b0) begin
      errors++; $display("FAIL rst_flags got %b%b want 00", halted, illegal_instr);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rel_req0 got %b want 0", mem_req); end
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      errors++; $display("FAIL first_fetch got req=%b addr=%h want req=1 addr=40", mem_req, mem_addr);
    end
    @(negedge clk); #1;
    checks++; if (state !== 4'd1 || pc !== 32'h44) begin
      errors++; $display("FAIL decode_pc got state=%0d pc=%h want state=1 pc=44", state, pc);
    end
  endtask

  task automatic test_alu();
    logic [31:0] exp_v [7];
    exp_v = '{32'd10, 32'd8, 32'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFF8};
    clear_prog();
    prog[16] = enc_i(OpAddi, 5'd0, 5'd1, 16'd5);
    prog[17] = enc_r(5'd1, 5'd1, 5'd2, FnAdd);
    prog[18] = enc_i(OpAddi, 5'd0, 5'd4, 16'hFFFD);
    prog[19] = enc_r(5'd1, 5'd4, 5'd5, FnSub);
    prog[20] = enc_r(5'd2, 5'd4, 5'd6, FnAnd);
    prog[21] = enc_r(5'd2, 5'd4, 5'd7, FnOr);
    prog[22] = enc_r(5'd4, 5'd1, 5'd8, FnSlt);
    prog[23] = enc_r(5'd1, 5'd4, 5'd9, FnSlt);
    prog[24] = enc_r(5'd4, 5'd1, 5'd10, FnSub);
    prog[25] = enc_i(OpSw, 5'd0, 5'd2, 16'h200);
    prog[26] = enc_i(OpSw, 5'd0, 5'd5, 16'h204);
    prog[27] = enc_i(OpSw, 5'd0, 5'd6, 16'h208);
    prog[28] = enc_i(OpSw, 5'd0, 5'd7, 16'h20C);
    prog[29] = enc_i(OpSw, 5'd0, 5'd8, 16'h210);
    prog[30] = enc_i(OpSw, 5'd0, 5'd9, 16'h214);
    prog[31] = enc_i(OpSw, 5'd0, 5'd10, 16'h218);
    prog[32] = enc_j(32'h80);
    do_reset(0);
    run(120);
    for (int i = 0; i < 7; i++) begin
      checks++; if (mem[128+i] !== exp_v[i]) begin
        errors++; $display("FAIL alu_result[%0d] got %h want %h", i, mem[128+i], exp_v[i]);
      end
    end
    checks++; if (fetch_cyc[18] - fetch_cyc[16] !== 8) begin
      errors++; $display("FAIL alu_latency got %0d want 8", fetch_cyc[18] - fetch_cyc[16]);
    end
  endtask

  task automatic test_mem_wait();
    clear_prog();
    prog[16] = enc_i(OpAddi, 5'd0, 5'd2, 16'd10);
    prog[17] = enc_i(OpSw, 5'd0, 5'd2, 16'd8);
    prog[18] = enc_i(OpLw, 5'd0, 5'd3, 16'd8);
    prog[19] = enc_i(OpSw, 5'd0, 5'd3, 16'h220);
    prog[20] = enc_j(32'h50);
    do_reset(3);
    run(80);
    checks++; if (first_wr_addr !== 32'd8 || first_wr_data !== 32'd10) begin
      errors++; $display("FAIL sw_bus got addr=%h data=%h want addr=8 data=a",
                         first_wr_addr, first_wr_data);
    end
    checks++; if (first_wr_hold !== 4) begin
      errors++; $display("FAIL sw_hold got %0d want 4", first_wr_hold);
    end
    checks++; if (mem[2] !== 32'd10) begin errors++; $display("FAIL sw_mem got %h want a", mem[2]); end
    checks++; if (mem[136] !== 32'd10) begin
      errors++; $display("FAIL lw_value got %h want a", mem[136]);
    end
    checks++; if (fetch_cyc[18] - fetch_cyc[17] !== 10) begin
      errors++; $display("FAIL sw_latency got %0d want 10", fetch_cyc[18] - fetch_cyc[17]);
    end
    checks++; if (fetch_cyc[19] - fetch_cyc[18] !== 11) begin
      errors++; $display("FAIL lw_latency got %0d want 11", fetch_cyc[19] - fetch_cyc[18]);
    end
  endtask

  task automatic test_branch();
    clear_prog();
    prog[16] = enc_i(OpAddi, 5'd0, 5'd1, 16'd1);
    prog[17] = enc_j(32'h10);
    prog[4]  = enc_i(OpBeq, 5'd1, 5'd1, 16'd2);
    prog[7]  = enc_i(OpBeq, 5'd1, 5'd0, 16'd5);
    prog[8]  = enc_j(32'h100);
    prog[64] = enc_j(32'h100);
    do_reset(0);
    run(40);
    checks++; if (fetch_cyc[4] - fetch_cyc[17] !== 3) begin
      errors++; $display("FAIL j_to_10 got %0d want 3", fetch_cyc[4] - fetch_cyc[17]);
    end
    checks++; if (fetch_cyc[7] - fetch_cyc[4] !== 3 || fetch_cyc[5] !== -1 || fetch_cyc[6] !== -1) begin
      errors++; $display("FAIL beq_taken got dt=%0d f14=%0d f18=%0d want 3 -1 -1",
                         fetch_cyc[7] - fetch_cyc[4], fetch_cyc[5], fetch_cyc[6]);
    end
    checks++; if (fetch_cyc[8] - fetch_cyc[7] !== 3 || fetch_cyc[13] !== -1) begin
      errors++; $display("FAIL beq_not_taken got dt=%0d f34=%0d want 3 -1",
                         fetch_cyc[8] - fetch_cyc[7], fetch_cyc[13]);
    end
    checks++; if (fetch_cyc[64] - fetch_cyc[8] !== 3) begin
      errors++; $display("FAIL j_to_100 got %0d want 3", fetch_cyc[64] - fetch_cyc[8]);
    end
  endtask

  task automatic test_illegal();
    clear_prog();
    prog[16] = 32'hFC00_0000;
    prog[17] = 32'h0000_0000;
    prog[18] = enc_i(OpAddi, 5'd0, 5'd5, 16'd3);
    prog[19] = enc_i(OpSw, 5'd0, 5'd5, 16'h230);
    prog[20] = enc_j(32'h50);
    do_reset(0);
    run(40);
    checks++; if (ill_cnt !== 2) begin errors++; $display("FAIL ill_pulses got %0d want 2", ill_cnt); end
    checks++; if (fetch_cyc[17] - fetch_cyc[16] !== 2 || fetch_cyc[18] - fetch_cyc[17] !== 2) begin
      errors++; $display("FAIL ill_next got %0d,%0d want 2,2",
                         fetch_cyc[17] - fetch_cyc[16], fetch_cyc[18] - fetch_cyc[17]);
    end
    checks++; if (mem[140] !== 32'd3 || halted !== 1'b0) begin
      errors++; $display("FAIL ill_continue got mem=%h halted=%b want 3 0", mem[140], halted);
    end
  endtask

  task automatic test_trap();
    int req_cnt = 0;
    int ill_n = 0;
    reset2 = 1'b0;
    @(negedge clk); #1;
    checks++; if (req2 !== 1'b0 || halt2 !== 1'b0) begin
      errors++; $display("FAIL trap_rst got req=%b halted=%b want 0 0", req2, halt2);
    end
    #1 reset2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (ill2) ill_n++;
      if (req2) begin
        req_cnt++;
        checks++; if (addr2 !== 16'h0008) begin
          errors++; $display("FAIL trap_addr got %h want 0008", addr2);
        end
      end
    end
    checks++; if (req_cnt !== 1 || ill_n !== 1) begin
      errors++; $display("FAIL trap_bus got req=%0d ill=%0d want 1 1", req_cnt, ill_n);
    end
    checks++; if (halt2 !== 1'b1 || state2 !== 4'd12 || pc2 !== 32'h0001_000C) begin
      errors++; $display("FAIL trap_halt got h=%b st=%0d pc=%h want 1 12 1000c", halt2, state2, pc2);
    end
  endtask

  task automatic test_reset_midaccess();
    bit found = 0;
    clear_prog();
    prog[16] = enc_i(OpAddi, 5'd0, 5'd2, 16'd9);
    prog[17] = enc_i(OpSw, 5'd0, 5'd2, 16'h240);
    prog[18] = enc_j(32'h48);
    do_reset(5);
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk); #1;
      if (mem_req && mem_we) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_find got no write want write"); end
    @(negedge clk);
    #2;
    clear_prog();
    prog[16]  = enc_i(OpAddi, 5'd0, 5'd0, 16'd7);
    prog[17]  = enc_i(OpSw, 5'd0, 5'd0, 16'h244);
    prog[18]  = enc_j(32'h48);
    prog[145] = 32'hDEAD_BEEF;
    reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL mid_abort got req=%b we=%b want 0 0", mem_req, mem_we);
    end
    checks++; if (pc !== 32'h40 || state !== 4'd0) begin
      errors++; $display("FAIL mid_rst got pc=%h st=%0d want 40 0", pc, state);
    end
    do_reset(0);
    run(30);
    checks++; if (fetch_cyc[16] !== 1) begin
      errors++; $display("FAIL mid_resume got %0d want 1", fetch_cyc[16]);
    end
    checks++; if (mem[145] !== 32'h0) begin errors++; $display("FAIL r0_zero got %h want 0", mem[145]); end
  endtask

  initial begin
    reset  = 1'b0;
    reset2 = 1'b0;
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch();
    test_illegal();
    test_trap();
    test_reset_midaccess();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
